// File: rtl/drum_step_sequencer.sv
// drum_step_sequencer: tempo-driven 16-step pattern sequencer emitting per-voice trigger pulses.
// Optional SWING_EN adds a swing input lengthening even steps and shortening odd steps.
module drum_step_sequencer #(
  parameter int VOICES  = 4,
  parameter int STEPS   = 16,
  parameter int TEMPO_W = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [TEMPO_W-1:0]         period,
`ifdef SWING_EN
  input  logic [TEMPO_W-1:0]         swing,
`endif
  input  logic                       play,
  input  logic                       stop,
  input  logic                       pat_we,
  input  logic [$clog2(VOICES)-1:0]  pat_voice,
  input  logic [$clog2(STEPS)-1:0]   pat_step,
  input  logic                       pat_bit,
  output logic [VOICES-1:0]          trig,
  output logic [$clog2(STEPS)-1:0]   step_idx,
  output logic                       beat,
  output logic                       running
);
  localparam int SW = $clog2(STEPS);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic [STEPS-1:0] pat [VOICES];
  logic [TEMPO_W:0] cnt, lim;
  logic [TEMPO_W-1:0] per;
  logic [SW-1:0] nxt;
  logic [VOICES-1:0] col0, coln;
  assign nxt = step_idx + 1'b1;
`ifdef SWING_EN
  logic [TEMPO_W-1:0] sw, sw_in;
  assign sw_in = (swing < period) ? swing : period;
  assign lim = step_idx[0] ? {1'b0, per} - {1'b0, sw} : {1'b0, per} + {1'b0, sw};
  always_ff @(posedge clk or posedge rst)
    if (rst) sw <= '0;
    else if (!stop && (play || (state == RUN && cnt == lim))) sw <= sw_in;
`else
  assign lim = {1'b0, per};
`endif
  always_comb begin
    col0 = '0;
    coln = '0;
    for (int v = 0; v < VOICES; v++) begin
      col0[v] = pat[v][0];
      coln[v] = pat[v][nxt];
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int v = 0; v < VOICES; v++) pat[v] <= '0;
    end else if (pat_we) begin
      pat[pat_voice][pat_step] <= pat_bit;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      per      <= '0;
      step_idx <= '0;
      trig     <= '0;
      beat     <= 1'b0;
      running  <= 1'b0;
    end else if (stop) begin
      state    <= IDLE;
      cnt      <= '0;
      step_idx <= '0;
      trig     <= '0;
      beat     <= 1'b0;
      running  <= 1'b0;
    end else if (play) begin
      state    <= RUN;
      cnt      <= '0;
      per      <= period;
      step_idx <= '0;
      trig     <= col0;
      beat     <= 1'b1;
      running  <= 1'b1;
    end else if (state == RUN) begin
      cnt      <= (cnt == lim) ? '0 : cnt + 1'b1;
      per      <= (cnt == lim) ? period : per;
      step_idx <= (cnt == lim) ? nxt : step_idx;
      trig     <= (cnt == lim) ? coln : '0;
      beat     <= (cnt == lim) && (nxt[1:0] == 2'd0);
    end else begin
      cnt      <= '0;
      step_idx <= '0;
      trig     <= '0;
      beat     <= 1'b0;
    end
endmodule

// File: tb/tb_drum_step_sequencer.sv
// tb_drum_step_sequencer: randomized and directed checks against a cycle-remaining step model.
module tb_drum_step_sequencer;
  localparam int VOICES = 4, STEPS = 16, TEMPO_W = 24;
  localparam int VW = $clog2(VOICES), SW = $clog2(STEPS);
  logic clk = 0, rst = 1, play = 0, stop = 0, pat_we = 0, pat_bit = 0;
  logic [TEMPO_W-1:0] period = '0, swing = '0;
  logic [VW-1:0] pat_voice = '0;
  logic [SW-1:0] pat_step = '0;
  logic [VOICES-1:0] trig;
  logic [SW-1:0] step_idx;
  logic beat, running;
  int nerr = 0, nchk = 0;
  always #5 clk = ~clk;
  drum_step_sequencer #(.VOICES(VOICES), .STEPS(STEPS), .TEMPO_W(TEMPO_W)) dut (
    .clk(clk), .rst(rst), .period(period),
`ifdef SWING_EN
    .swing(swing),
`endif
    .play(play), .stop(stop), .pat_we(pat_we), .pat_voice(pat_voice),
    .pat_step(pat_step), .pat_bit(pat_bit), .trig(trig), .step_idx(step_idx),
    .beat(beat), .running(running));

  logic [STEPS-1:0] pm [VOICES];
  logic [VOICES-1:0] mtrig;
  logic mbeat, mrun;
  int mstep, mrem;

  function automatic int steplen(int s, int p, int w);
`ifdef SWING_EN
    int m = (w < p) ? w : p;
    return (s % 2 == 0) ? p + 1 + m : p + 1 - m;
`else
    return p + 1;
`endif
  endfunction

  function automatic logic [VOICES-1:0] column(int s);
    logic [VOICES-1:0] c;
    for (int v = 0; v < VOICES; v++) c[v] = pm[v][s];
    return c;
  endfunction

  always @(posedge clk or posedge rst)
    if (rst) begin
      for (int v = 0; v < VOICES; v++) pm[v] = '0;
      mtrig = '0; mbeat = 0; mrun = 0; mstep = 0; mrem = 0;
    end else begin
      if (stop) begin
        mrun = 0; mstep = 0; mtrig = '0; mbeat = 0;
      end else if (play) begin
        mrun = 1; mstep = 0; mrem = steplen(0, int'(period), int'(swing)) - 1;
        mtrig = column(0); mbeat = 1;
      end else if (mrun && mrem == 0) begin
        mstep = (mstep + 1) % STEPS;
        mrem = steplen(mstep, int'(period), int'(swing)) - 1;
        mtrig = column(mstep); mbeat = (mstep % 4 == 0);
      end else begin
        if (mrun) mrem--;
        mtrig = '0; mbeat = 0;
      end
      if (pat_we) pm[pat_voice][pat_step] = pat_bit;
    end

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
    chk("trig", 32'(trig), 32'(mtrig));
    chk("beat", 32'(beat), 32'(mbeat));
    chk("step_idx", 32'(step_idx), 32'(mstep));
    chk("running", 32'(running), 32'(mrun));
  endtask

  task automatic wr(int v, int s, logic b);
    pat_we = 1; pat_voice = VW'(v); pat_step = SW'(s); pat_bit = b;
    cyc();
    pat_we = 0;
  endtask

  task automatic do_stop();
    stop = 1; cyc(); stop = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_trig", 32'(trig), 0);
    chk("rst_run", 32'(running), 0);
    chk("rst_step", 32'(step_idx), 0);
    rst = 0;
    for (int s = 0; s < 16; s += 4) wr(0, s, 1);
    // beat every 16 cycles, voice0 hits on beats
    period = 3; play = 1;
    for (int k = 1; k <= 52; k++) begin
      cyc(); play = 0;
      chk("t1_trig0", 32'(trig[0]), 32'(k % 16 == 1));
      chk("t1_beat", 32'(beat), 32'(k % 16 == 1));
      chk("t1_step", 32'(step_idx), 32'(((k - 1) / 4) % 16));
    end
    do_stop();
    wr(1, 15, 1);
    period = 0; play = 1;
    for (int k = 1; k <= 40; k++) begin
      cyc(); play = 0;
      chk("wrap_step", 32'(step_idx), 32'((k - 1) % 16));
      chk("wrap_trig1", 32'(trig[1]), 32'((k - 1) % 16 == 15));
    end
    do_stop();
    period = 9; play = 1;
    for (int k = 1; k <= 22; k++) begin
      cyc(); play = 0;
      if (k == 3) period = 4;
      if (k == 10) chk("tempo_k10", 32'(step_idx), 0);
      if (k == 11) chk("tempo_k11", 32'(step_idx), 1);
      if (k == 15) chk("tempo_k15", 32'(step_idx), 1);
      if (k == 16) chk("tempo_k16", 32'(step_idx), 2);
      if (k == 21) chk("tempo_k21", 32'(step_idx), 3);
    end
    do_stop();
    period = 3; play = 1;
    for (int k = 1; k <= 4; k++) begin cyc(); play = 0; end
    do_stop();
    chk("stopb_trig", 32'(trig), 0);
    chk("stopb_step", 32'(step_idx), 0);
    chk("stopb_run", 32'(running), 0);
    play = 1; cyc(); play = 0;
    chk("replay_trig0", 32'(trig[0]), 1);
    chk("replay_run", 32'(running), 1);
    do_stop();
    play = 1; stop = 1; cyc(); play = 0; stop = 0;
    chk("ps_run", 32'(running), 0);
    chk("ps_trig", 32'(trig), 0);
    chk("ps_beat", 32'(beat), 0);
    play = 1;
    for (int k = 1; k <= 86; k++) begin
      cyc(); play = 0; pat_we = 0;
      if (k == 20) begin pat_we = 1; pat_voice = 2; pat_step = 5; pat_bit = 1; end
      if (k == 21) chk("wr_same_edge", 32'(trig[2]), 0);
      if (k == 85) chk("wr_next_pass", 32'(trig[2]), 1);
    end
    do_stop();
`ifdef SWING_EN
    period = 9; swing = 3; play = 1;
    for (int k = 1; k <= 21; k++) begin
      cyc(); play = 0;
      if (k == 13) chk("swing_k13", 32'(step_idx), 0);
      if (k == 14) chk("swing_k14", 32'(step_idx), 1);
      if (k == 20) chk("swing_k20", 32'(step_idx), 1);
      if (k == 21) chk("swing_k21", 32'(step_idx), 2);
    end
    do_stop();
`endif
    for (int i = 0; i < 3000; i++) begin
      play = ($urandom_range(0, 40) == 0);
      stop = ($urandom_range(0, 80) == 0);
      pat_we = ($urandom_range(0, 3) == 0);
      pat_voice = VW'($urandom); pat_step = SW'($urandom); pat_bit = $urandom_range(0, 1);
      if ($urandom_range(0, 30) == 0) period = TEMPO_W'($urandom_range(0, 5));
      if ($urandom_range(0, 30) == 0) swing = TEMPO_W'($urandom_range(0, 4));
      cyc();
    end
    play = 0; stop = 0; pat_we = 0; swing = 0;
    period = 2; play = 1;
    for (int k = 0; k < 5; k++) begin cyc(); play = 0; end
    #3 rst = 1; #1;
    chk("arst_trig", 32'(trig), 0);
    chk("arst_run", 32'(running), 0);
    chk("arst_step", 32'(step_idx), 0);
    chk("arst_beat", 32'(beat), 0);
    @(posedge clk); #1 rst = 0;
    period = 0; play = 1;
    for (int k = 1; k <= 20; k++) begin
      cyc(); play = 0;
      chk("arst_pat_clear", 32'(trig), 0);
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/drum_step_sequencer.md
Name: drum_step_sequencer

Overview:
Tempo-driven step sequencer for the drum machine. It generates its own step tick from a programmable cycle count, walks a 16-step pattern stored per voice, and emits one-cycle trigger pulses to the voice generators. It owns start/stop sequencing and the pattern store; the CPU/button logic writes patterns and the tempo value.

Parameters:
VOICES, 4, number of drum voices (trigger outputs / pattern rows)
STEPS, 16, steps per pattern; power of two, >= 4
TEMPO_W, 24, width of the step period count

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
period  in  TEMPO_W  clock cycles per step minus 1
play  in  1  start pulse
stop  in  1  stop pulse
pat_we  in  1  pattern write strobe
pat_voice  in  $clog2(VOICES)  voice row to write
pat_step  in  $clog2(STEPS)  step column to write
pat_bit  in  1  value written (1 = hit)
trig  out  VOICES  one-cycle hit pulse per voice
step_idx  out  $clog2(STEPS)  current step
beat  out  1  one-cycle pulse when a step with step_idx[1:0]==0 starts
running  out  1  high while in RUN

Behaviour:
- Reset: state IDLE, trig=0, beat=0, step_idx=0, running=0, tick counter=0, latched period=0, entire pattern store cleared to 0. Reset mid-run aborts immediately; no trailing pulses.
- States: IDLE, RUN.
- IDLE: counter held at 0, step_idx=0, trig/beat=0. play (and not stop) -> RUN; on that edge step_idx<=0, period latched, counter<=0, trig<=pattern[*][0], beat<=1, running<=1. Triggers for step 0 therefore appear in the cycle after play is sampled.
- RUN: counter increments each cycle. When counter==latched period: counter<=0, step_idx<=step_idx+1 (wraps STEPS-1 -> 0), trig<=pattern[*][next], beat<=(next[1:0]==0), period re-latched. Otherwise trig<=0, beat<=0.
- Step length = latched period+1 cycles; period==0 yields a step every cycle with trig/beat re-evaluated each cycle (back-to-back pulses are legal).
- Changes to period take effect at the next step boundary, never mid-step.
- stop in RUN -> IDLE next edge: running<=0, step_idx<=0, counter<=0, trig/beat<=0, even if a boundary coincides.
- play and stop in the same cycle: stop wins (IDLE, or -> IDLE).
- play while in RUN: restart; behaves exactly as play from IDLE (step 0 fires next cycle).
- Pattern write: one bit per cycle, allowed in any state. A write to the column being loaded on the same edge is not seen by that trigger (old value fires); the new value fires on the next visit.
- trig, beat, step_idx, running are all registered outputs; no combinational path from inputs.

Optional Feature:
SWING_EN: adds input swing [TEMPO_W-1:0]. Steps with even step_idx last period+1+s cycles, odd steps period+1-s cycles, where s=min(swing, period), latched with period at each boundary. Pair length is constant at 2*(period+1). Without SWING_EN: no swing port; every step lasts period+1 cycles.

Test Plan:
- Reset then play with period=3, pattern voice0 = steps 0,4,8,12 -> trig[0] high in cycles 1,17,33,49 after play; beat on the same cycles; step_idx advances every 4 cycles.
- Wrap: period=0, voice1 bit at step 15 only, run 40 cycles -> trig[1] pulses every 16 cycles; step_idx goes 15 -> 0 with no gap.
- Tempo change mid-step: period=9, write period=4 at counter=2 -> current step still lasts 10 cycles, following steps last 5.
- stop at the same cycle as a step boundary -> no trig that edge, step_idx=0, running=0; subsequent play restarts at step 0 with trig next cycle.
- play+stop same cycle while IDLE -> stays IDLE, no pulses. Write pat_bit=1 to the step being entered on that edge -> no trig now; trig fires on the next pass.
- Async rst asserted mid-RUN between clock edges -> outputs 0 immediately; pattern reads back all-zero (no trig after replay). With SWING_EN, period=9, swing=3 -> even steps 13 cycles, odd steps 7 cycles.
